// File: rtl/frame_capture_sink_if.sv
// Pixel-write, control and raster-readout signals for frame_capture_sink.
// The pipeline/display side uses master; the sink uses slave.
interface frame_capture_sink_if #(
  parameter int unsigned WIDTH_BITS  = 8,
  parameter int unsigned HEIGHT_BITS = 8,
  parameter int unsigned COLOR_BITS  = 3
);
  logic [WIDTH_BITS-1:0]    x;
  logic [HEIGHT_BITS-1:0]   y;
  logic [COLOR_BITS-1:0]    r;
  logic [COLOR_BITS-1:0]    g;
  logic [COLOR_BITS-1:0]    b;
  logic                     wren;
  logic                     start;
  logic                     clear;
  logic                     ready;
  logic [WIDTH_BITS-1:0]    col;
  logic [HEIGHT_BITS-1:0]   row;
  logic [3*COLOR_BITS-1:0]  data;
  logic                     valid;
  logic                     last;
  logic                     frame_done;
  logic [1:0]               state;
  logic [7:0]               drop_count;

  modport master (
    output x, y, r, g, b, wren, start, clear, ready,
    input  col, row, data, valid, last, frame_done, state, drop_count
  );

  modport slave (
    input  x, y, r, g, b, wren, start, clear, ready,
    output col, row, data, valid, last, frame_done, state, drop_count
  );
endinterface

// File: rtl/frame_capture_sink.sv
// Captures one full frame of pixel writes, then replays it in raster order
// over a valid/ready stream. Storage is not cleared by reset.
module frame_capture_sink #(
  parameter int unsigned WIDTH_BITS  = 8,
  parameter int unsigned HEIGHT_BITS = 8,
  parameter int unsigned COLOR_BITS  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  frame_capture_sink_if.slave  bus
);
  localparam int unsigned ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam int unsigned DATA_BITS = 3 * COLOR_BITS;
  localparam logic [ADDR_BITS:0]   LAST_COUNT = {1'b0, {ADDR_BITS{1'b1}}};
  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = '1;

  typedef enum logic [1:0] {
    CAPTURE = 2'd1,
    READY   = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [ADDR_BITS:0]     wr_count;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [DATA_BITS-1:0]   mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0]   data;
  logic [WIDTH_BITS-1:0]  col;
  logic [HEIGHT_BITS-1:0] row;
  logic                   valid;
  logic                   last;
  logic [7:0]             drop_count;

  logic capture_wr;
  logic rearm;
  logic start_readout;
  logic issue;
  logic retire;
  logic drop;

  always_ff @(posedge clock) begin
    if (reset) state <= CAPTURE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    capture_wr    = 1'b0;
    rearm         = 1'b0;
    start_readout = 1'b0;
    issue         = 1'b0;
    retire        = 1'b0;
    drop          = 1'b0;
    case (state)
      CAPTURE: begin
        capture_wr = bus.wren;
        if (bus.wren && wr_count == LAST_COUNT) state_next = READY;
      end
      READY: begin
        drop = bus.wren;
        if (bus.clear) begin
          rearm      = 1'b1;
          state_next = CAPTURE;
        end else if (bus.start) begin
          start_readout = 1'b1;
          state_next    = READOUT;
        end
      end
      READOUT: begin
        drop   = bus.wren;
        retire = valid && bus.ready;
        // Fetch only when the output stage is empty or draining, and never past the final beat.
        issue  = (!valid || bus.ready) && !(valid && last);
        if (retire && last) state_next = READY;
      end
      default: state_next = CAPTURE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (capture_wr) mem[{bus.y, bus.x}] <= {bus.r, bus.g, bus.b};
  end

  // The synchronous read is clock-enabled by issue, so the read register
  // doubles as the stalled output holding stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count   <= '0;
      rd_addr    <= '0;
      data       <= '0;
      col        <= '0;
      row        <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
      drop_count <= '0;
    end else begin
      if (capture_wr)  wr_count <= wr_count + 1'b1;
      else if (rearm)  wr_count <= '0;

      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;

      if (start_readout) begin
        rd_addr <= '0;
      end else if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        data    <= mem[rd_addr];
        col     <= rd_addr[WIDTH_BITS-1:0];
        row     <= rd_addr[ADDR_BITS-1:WIDTH_BITS];
        last    <= (rd_addr == LAST_ADDR);
        valid   <= 1'b1;
      end else if (retire) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end
    end
  end

  assign bus.col        = col;
  assign bus.row        = row;
  assign bus.data       = data;
  assign bus.valid      = valid;
  assign bus.last       = last;
  assign bus.frame_done = (state == READY);
  assign bus.state      = state;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_frame_capture_sink.sv
// Bench for frame_capture_sink on a reduced 8x4 frame: table-driven control
// vectors plus a beat scoreboard checked on every valid cycle.
module tb_frame_capture_sink;
  localparam int unsigned WB     = 3;
  localparam int unsigned HB     = 2;
  localparam int unsigned CB     = 3;
  localparam int unsigned DB     = 3 * CB;
  localparam int unsigned W      = 2**WB;
  localparam int unsigned PIXELS = 2**(WB + HB);

  logic clock;
  logic reset;

  frame_capture_sink_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .COLOR_BITS(CB)) bus ();

  frame_capture_sink #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .COLOR_BITS(CB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [WB-1:0] col;
    logic [HB-1:0] row;
    logic [DB-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic        wren;
    logic        start;
    logic        clear;
    int unsigned reps;
    logic [1:0]  exp_state;
    logic        exp_done;
    logic [7:0]  exp_drop;
  } vec_t;

  beat_t         exp_q[$];
  logic [DB-1:0] model [PIXELS];
  vec_t          tbl [6];
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    beat_t e;
    if (!reset && bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(bus.valid), 0);
      end else begin
        e = exp_q[0];
        check("beat_col",  32'(bus.col),  32'(e.col));
        check("beat_row",  32'(bus.row),  32'(e.row));
        check("beat_data", 32'(bus.data), 32'(e.data));
        check("beat_last", 32'(bus.last), 32'(e.last));
        if (bus.ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic write_pixel(input int unsigned xi, input int unsigned yi, input logic [DB-1:0] d);
    bus.x    = WB'(xi);
    bus.y    = HB'(yi);
    bus.r    = d[DB-1 -: CB];
    bus.g    = d[2*CB-1 -: CB];
    bus.b    = d[CB-1:0];
    bus.wren = 1'b1;
    @(posedge clock); #1;
    bus.wren = 1'b0;
  endtask

  task automatic apply_vec(input int unsigned i);
    for (int unsigned n = 0; n < tbl[i].reps; n++) begin
      bus.wren  = tbl[i].wren;
      bus.start = tbl[i].start;
      bus.clear = tbl[i].clear;
      bus.x     = WB'($urandom);
      bus.y     = HB'($urandom);
      bus.r     = '1;
      bus.g     = '0;
      bus.b     = '1;
      @(posedge clock); #1;
    end
    bus.wren  = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check($sformatf("vec%0d_state", i), 32'(bus.state),      32'(tbl[i].exp_state));
    check($sformatf("vec%0d_done", i),  32'(bus.frame_done), 32'(tbl[i].exp_done));
    check($sformatf("vec%0d_drop", i),  32'(bus.drop_count), 32'(tbl[i].exp_drop));
    check($sformatf("vec%0d_valid", i), 32'(bus.valid),      0);
  endtask

  // mode 0: ready held high, 1: toggling, 2: random. reset_at>0 resets while beat reset_at is presented.
  task automatic readout(input int unsigned mode, input int unsigned reset_at);
    int unsigned cycles = 0;
    for (int unsigned k = 0; k < PIXELS; k++)
      exp_q.push_back('{col: WB'(k % W), row: HB'(k / W), data: model[k], last: (k == PIXELS - 1)});
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.ready = 1'b1;
    check("lat_n1_valid", 32'(bus.valid), 0);
    check("lat_n1_state", 32'(bus.state), 3);
    @(posedge clock); #1;
    check("lat_n2_valid", 32'(bus.valid), 1);
    while (exp_q.size() > 0 && cycles < 20 * PIXELS) begin
      case (mode)
        0:       bus.ready = 1'b1;
        1:       bus.ready = ~bus.ready;
        default: bus.ready = 1'($urandom_range(0, 1));
      endcase
      if (reset_at != 0 && PIXELS - exp_q.size() == reset_at) reset = 1'b1;
      @(posedge clock); #1;
      cycles++;
      if (reset) begin
        reset = 1'b0;
        check("rst_valid", 32'(bus.valid),      0);
        check("rst_last",  32'(bus.last),       0);
        check("rst_state", 32'(bus.state),      1);
        check("rst_drop",  32'(bus.drop_count), 0);
        check("rst_done",  32'(bus.frame_done), 0);
        exp_q.delete();
        return;
      end
    end
    check("readout_remaining", exp_q.size(), 0);
    if (mode == 0) check("no_bubbles", cycles, PIXELS);
    check("end_valid", 32'(bus.valid),      0);
    check("end_last",  32'(bus.last),       0);
    check("end_state", 32'(bus.state),      2);
    check("end_done",  32'(bus.frame_done), 1);
  endtask

  initial begin
    logic [2:0] c;
    tbl[0] = '{wren: 1, start: 0, clear: 0, reps: 1,   exp_state: 2, exp_done: 1, exp_drop: 1};
    tbl[1] = '{wren: 1, start: 0, clear: 0, reps: 299, exp_state: 2, exp_done: 1, exp_drop: 255};
    tbl[2] = '{wren: 0, start: 0, clear: 0, reps: 3,   exp_state: 2, exp_done: 1, exp_drop: 255};
    tbl[3] = '{wren: 0, start: 1, clear: 1, reps: 1,   exp_state: 1, exp_done: 0, exp_drop: 255};
    tbl[4] = '{wren: 0, start: 1, clear: 0, reps: 1,   exp_state: 1, exp_done: 0, exp_drop: 255};
    tbl[5] = '{wren: 0, start: 0, clear: 1, reps: 1,   exp_state: 1, exp_done: 0, exp_drop: 255};

    reset = 1'b1;
    bus.x = '0; bus.y = '0; bus.r = '0; bus.g = '0; bus.b = '0;
    bus.wren = 1'b0; bus.start = 1'b0; bus.clear = 1'b0; bus.ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_state", 32'(bus.state),      1);
    check("reset_valid", 32'(bus.valid),      0);
    check("reset_last",  32'(bus.last),       0);
    check("reset_data",  32'(bus.data),       0);
    check("reset_col",   32'(bus.col),        0);
    check("reset_row",   32'(bus.row),        0);
    check("reset_done",  32'(bus.frame_done), 0);
    check("reset_drop",  32'(bus.drop_count), 0);

    // Full frame in reverse raster order; start/clear mid-capture must be ignored.
    for (int i = PIXELS - 1; i >= 0; i--) begin
      c = 3'((i % W) ^ (i / W));
      model[i] = {c, c, c};
      if (i == PIXELS / 2) begin
        bus.start = 1'b1;
        bus.clear = 1'b1;
      end
      write_pixel(i % W, i / W, model[i]);
      bus.start = 1'b0;
      bus.clear = 1'b0;
      if (i == PIXELS / 2) check("capture_ignores_ctrl", 32'(bus.state), 1);
      if (i == 1) check("done_before_last", 32'(bus.frame_done), 0);
    end
    check("frame_done", 32'(bus.frame_done), 1);
    check("frame_state", 32'(bus.state), 2);
    check("capture_no_drop", 32'(bus.drop_count), 0);

    readout(0, 0);
    for (int unsigned i = 0; i < 3; i++) apply_vec(i);
    readout(2, 0);
    for (int unsigned i = 3; i < 6; i++) apply_vec(i);
    repeat (4) @(posedge clock);
    #1;
    check("cleared_no_valid", 32'(bus.valid), 0);

    for (int unsigned i = 0; i < PIXELS; i++) begin
      model[i] = '1;
      write_pixel(i % W, i / W, model[i]);
      if (i == PIXELS - 2) check("rewrite_done_early", 32'(bus.frame_done), 0);
    end
    check("rewrite_done", 32'(bus.frame_done), 1);
    readout(1, 0);
    readout(0, 20);

    // Count restarts from zero after reset; duplicate addresses still count.
    for (int unsigned i = 0; i < PIXELS - 1; i++) write_pixel(0, 0, '1);
    check("dup_done_early", 32'(bus.frame_done), 0);
    check("dup_state_early", 32'(bus.state), 1);
    write_pixel(0, 0, '1);
    check("dup_done", 32'(bus.frame_done), 1);
    check("dup_state", 32'(bus.state), 2);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
